mem_wb_stage: RTL and testbench

- Consumer side of the EX/MEM pipeline register.
- Takes the MEM-stage bundle and performs the data-memory access through a req/ack handshake to a multi-cycle data memory.
- Stalls upstream stages while an access is outstanding.
- Registers the result into the MEM/WB boundary for register-file writeback.

---
 rtl/mem_wb_stage.sv | 233 +++++++++++++++++++++++
 tb/tb_mem_wb_stage.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM-stage data-memory access and MEM/WB boundary register.
// Consumes the EX/MEM bundle and performs loads/stores through a req/ack
// handshake to a multi-cycle data memory. It freezes the upstream pipeline
// while an access is outstanding and registers the result for writeback.
// Optional feature: define MEM_TIMEOUT_EN to abort an access that sees no
// DM_ACK within TIMEOUT_CYCLES ACCESS cycles and flag it on WB_ERR.
// Without the macro, ACCESS waits indefinitely and WB_ERR is tied low.
module mem_wb_stage #(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 16,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst,
  // MEM-stage bundle from the EX/MEM register
  input  logic              MEM_VALID,
  input  logic              MEM_DM_WE,
  input  logic              MEM_DM_RE,
  input  logic [DATA_W-1:0] MEM_ALU_RES,
  input  logic [DATA_W-1:0] MEM_muxB,
  input  logic [ADDR_W-1:0] MEM_DM_ADDR,
  input  logic              MEM_NEXT_PC,
  input  logic              MEM_RF_D_SEL,
  output logic              MEM_STALL,
  // data-memory handshake
  output logic              DM_REQ,
  output logic              DM_WE,
  output logic [ADDR_W-1:0] DM_ADDR,
  output logic [DATA_W-1:0] DM_WDATA,
  input  logic              DM_ACK,
  input  logic [DATA_W-1:0] DM_RDATA,
  // MEM/WB boundary
  output logic              WB_VALID,
  output logic [DATA_W-1:0] WB_ALU_RES,
  output logic [DATA_W-1:0] WB_DM_RDATA,
  output logic              WB_NEXT_PC,
  output logic              WB_RF_D_SEL,
  output logic              WB_ERR
);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  state_t state_r;
  state_t state_nxt_s;

  // Handshake / control
  logic acc_s;     // instruction in MEM needs the data memory
  logic start_s;   // launch a memory access on the next edge
  logic pass_s;    // non-memory instruction goes straight to WB
  logic done_s;    // memory acknowledged the outstanding access
  logic abort_s;   // outstanding access gave up waiting

  // Memory-side registers
  logic              dm_req_r;
  logic              dm_we_r;
  logic [ADDR_W-1:0] dm_addr_r;
  logic [DATA_W-1:0] dm_wdata_r;

  // Fields captured at launch; EX/MEM may already have advanced on completion
  logic [DATA_W-1:0] alu_cap_r;
  logic              next_pc_cap_r;
  logic              rf_d_sel_cap_r;

  // WB-side registers
  logic              wb_valid_r;
  logic [DATA_W-1:0] wb_alu_res_r;
  logic [DATA_W-1:0] wb_dm_rdata_r;
  logic              wb_next_pc_r;
  logic              wb_rf_d_sel_r;

  // A store with RE also set is still a store; RE only matters when WE is low.
  assign acc_s = MEM_VALID & (MEM_DM_WE | MEM_DM_RE);

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] to_cnt_r;
  logic             wb_err_r;

  // Abort fires in the ACCESS cycle that would be the TIMEOUT_CYCLES-th
  // without ack; an ack in that same cycle still completes normally.
  assign abort_s = (state_r == ACCESS) & ~DM_ACK & (to_cnt_r == CNT_LAST);

  // Wait counter: held at zero outside ACCESS so it is clear on entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt_r <= {CNT_W{1'b0}};
    end else if (state_r == IDLE) begin
      to_cnt_r <= {CNT_W{1'b0}};
    end else if (!DM_ACK) begin
      to_cnt_r <= to_cnt_r + CNT_W'(1);
    end else begin
      to_cnt_r <= to_cnt_r;
    end
  end

  // Error flag: set by an abort, cleared by the next real WB load.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_err_r <= 1'b0;
    end else if (abort_s) begin
      wb_err_r <= 1'b1;
    end else if (pass_s || done_s) begin
      wb_err_r <= 1'b0;
    end else begin
      wb_err_r <= wb_err_r;
    end
  end

  assign WB_ERR = wb_err_r;
`else
  assign abort_s = 1'b0;
  assign WB_ERR  = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state and per-cycle action decode.
  always_comb begin
    state_nxt_s = state_r;
    start_s     = 1'b0;
    pass_s      = 1'b0;
    done_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (acc_s) begin
          start_s     = 1'b1;
          state_nxt_s = ACCESS;
        end else if (MEM_VALID) begin
          pass_s      = 1'b1;
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ACCESS: begin
        if (DM_ACK) begin
          done_s      = 1'b1;
          state_nxt_s = IDLE;
        end else if (abort_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = ACCESS;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Stall drops in the completing cycle so EX/MEM advances on the same edge
  // that registers the WB result.
  assign MEM_STALL = acc_s & ~done_s & ~abort_s;

  // Memory request registers: launched from IDLE, dropped on ack or abort.
  always_ff @(posedge clk) begin
    if (rst) begin
      dm_req_r       <= 1'b0;
      dm_we_r        <= 1'b0;
      dm_addr_r      <= {ADDR_W{1'b0}};
      dm_wdata_r     <= {DATA_W{1'b0}};
      alu_cap_r      <= {DATA_W{1'b0}};
      next_pc_cap_r  <= 1'b0;
      rf_d_sel_cap_r <= 1'b0;
    end else if (start_s) begin
      dm_req_r       <= 1'b1;
      dm_we_r        <= MEM_DM_WE;
      dm_addr_r      <= MEM_DM_ADDR;
      dm_wdata_r     <= MEM_muxB;
      alu_cap_r      <= MEM_ALU_RES;
      next_pc_cap_r  <= MEM_NEXT_PC;
      rf_d_sel_cap_r <= MEM_RF_D_SEL;
    end else if (done_s || abort_s) begin
      dm_req_r       <= 1'b0;
    end else begin
      dm_req_r       <= dm_req_r;
    end
  end

  // MEM/WB boundary: bubble while launching or waiting, load on completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid_r    <= 1'b0;
      wb_alu_res_r  <= {DATA_W{1'b0}};
      wb_dm_rdata_r <= {DATA_W{1'b0}};
      wb_next_pc_r  <= 1'b0;
      wb_rf_d_sel_r <= 1'b0;
    end else if (pass_s) begin
      wb_valid_r    <= 1'b1;
      wb_alu_res_r  <= MEM_ALU_RES;
      wb_dm_rdata_r <= {DATA_W{1'b0}};
      wb_next_pc_r  <= MEM_NEXT_PC;
      wb_rf_d_sel_r <= MEM_RF_D_SEL;
    end else if (done_s) begin
      wb_valid_r    <= 1'b1;
      wb_alu_res_r  <= alu_cap_r;
      wb_dm_rdata_r <= dm_we_r ? {DATA_W{1'b0}} : DM_RDATA;
      wb_next_pc_r  <= next_pc_cap_r;
      wb_rf_d_sel_r <= rf_d_sel_cap_r;
    end else if (abort_s) begin
      wb_valid_r    <= 1'b1;
      wb_alu_res_r  <= alu_cap_r;
      wb_dm_rdata_r <= {DATA_W{1'b0}};
      wb_next_pc_r  <= next_pc_cap_r;
      wb_rf_d_sel_r <= rf_d_sel_cap_r;
    end else begin
      wb_valid_r    <= 1'b0;
    end
  end

  assign DM_REQ      = dm_req_r;
  assign DM_WE       = dm_we_r;
  assign DM_ADDR     = dm_addr_r;
  assign DM_WDATA    = dm_wdata_r;
  assign WB_VALID    = wb_valid_r;
  assign WB_ALU_RES  = wb_alu_res_r;
  assign WB_DM_RDATA = wb_dm_rdata_r;
  assign WB_NEXT_PC  = wb_next_pc_r;
  assign WB_RF_D_SEL = wb_rf_d_sel_r;

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: directed self-checking bench for mem_wb_stage.
// The MEM_* inputs model the EX/MEM register: they are changed only right
// after a rising edge, and only when MEM_STALL was low in the cycle before.
module tb_mem_wb_stage;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 16;
  localparam int TO     = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              MEM_VALID;
  logic              MEM_DM_WE;
  logic              MEM_DM_RE;
  logic [DATA_W-1:0] MEM_ALU_RES;
  logic [DATA_W-1:0] MEM_muxB;
  logic [ADDR_W-1:0] MEM_DM_ADDR;
  logic              MEM_NEXT_PC;
  logic              MEM_RF_D_SEL;
  logic              MEM_STALL;
  logic              DM_REQ;
  logic              DM_WE;
  logic [ADDR_W-1:0] DM_ADDR;
  logic [DATA_W-1:0] DM_WDATA;
  logic              DM_ACK;
  logic [DATA_W-1:0] DM_RDATA;
  logic              WB_VALID;
  logic [DATA_W-1:0] WB_ALU_RES;
  logic [DATA_W-1:0] WB_DM_RDATA;
  logic              WB_NEXT_PC;
  logic              WB_RF_D_SEL;
  logic              WB_ERR;

  int n_cmp = 0;
  int n_bad = 0;

  mem_wb_stage #(
    .DATA_W        (DATA_W),
    .ADDR_W        (ADDR_W),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .MEM_VALID   (MEM_VALID),
    .MEM_DM_WE   (MEM_DM_WE),
    .MEM_DM_RE   (MEM_DM_RE),
    .MEM_ALU_RES (MEM_ALU_RES),
    .MEM_muxB    (MEM_muxB),
    .MEM_DM_ADDR (MEM_DM_ADDR),
    .MEM_NEXT_PC (MEM_NEXT_PC),
    .MEM_RF_D_SEL(MEM_RF_D_SEL),
    .MEM_STALL   (MEM_STALL),
    .DM_REQ      (DM_REQ),
    .DM_WE       (DM_WE),
    .DM_ADDR     (DM_ADDR),
    .DM_WDATA    (DM_WDATA),
    .DM_ACK      (DM_ACK),
    .DM_RDATA    (DM_RDATA),
    .WB_VALID    (WB_VALID),
    .WB_ALU_RES  (WB_ALU_RES),
    .WB_DM_RDATA (WB_DM_RDATA),
    .WB_NEXT_PC  (WB_NEXT_PC),
    .WB_RF_D_SEL (WB_RF_D_SEL),
    .WB_ERR      (WB_ERR)
  );

  // 10-unit clock
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // advance one clock; returns 1 time unit after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_mem(input logic v, input logic we, input logic re,
                         input logic [31:0] alu, input logic [31:0] wd,
                         input logic [15:0] addr, input logic npc, input logic rfs);
    MEM_VALID    = v;
    MEM_DM_WE    = we;
    MEM_DM_RE    = re;
    MEM_ALU_RES  = alu;
    MEM_muxB     = wd;
    MEM_DM_ADDR  = addr;
    MEM_NEXT_PC  = npc;
    MEM_RF_D_SEL = rfs;
  endtask

  task automatic set_idle();
    set_mem(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 16'h0, 1'b0, 1'b0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".req"},   32'(DM_REQ),      32'h0);
    chk({tag, ".we"},    32'(DM_WE),       32'h0);
    chk({tag, ".addr"},  32'(DM_ADDR),     32'h0);
    chk({tag, ".wdata"}, DM_WDATA,         32'h0);
    chk({tag, ".wbv"},   32'(WB_VALID),    32'h0);
    chk({tag, ".alu"},   WB_ALU_RES,       32'h0);
    chk({tag, ".rdata"}, WB_DM_RDATA,      32'h0);
    chk({tag, ".npc"},   32'(WB_NEXT_PC),  32'h0);
    chk({tag, ".rfs"},   32'(WB_RF_D_SEL), 32'h0);
    chk({tag, ".err"},   32'(WB_ERR),      32'h0);
    chk({tag, ".stall"}, 32'(MEM_STALL),   32'h0);
  endtask

  // One memory op: arrival cycle, n_wait ACCESS cycles without ack, then the
  // ack cycle. Returns right after the completing edge with WB checked; the
  // caller then loads the next EX/MEM contents.
  task automatic mem_op(input string tag, input logic we, input logic re,
                        input logic [15:0] addr, input logic [31:0] wd,
                        input logic [31:0] alu, input logic npc, input logic rfs,
                        input int n_wait, input logic [31:0] rd,
                        input logic [31:0] exp_rdata);
    int req_cnt;
    int stall_cnt;
    set_mem(1'b1, we, re, alu, wd, addr, npc, rfs);
    #1;
    chk({tag, ".arr_stall"}, 32'(MEM_STALL), 32'h1);
    chk({tag, ".arr_req"},   32'(DM_REQ),    32'h0);
    req_cnt   = 0;
    stall_cnt = 1;
    for (int c = 1; c <= n_wait + 1; c++) begin
      step();
      if (c == n_wait + 1) begin
        DM_ACK   = 1'b1;
        DM_RDATA = rd;
      end
      #1;
      req_cnt   += int'(DM_REQ);
      stall_cnt += int'(MEM_STALL);
      chk({tag, ".stall"}, 32'(MEM_STALL), (c <= n_wait) ? 32'h1 : 32'h0);
      chk({tag, ".dm_we"}, 32'(DM_WE),     32'(we));
      chk({tag, ".addr"},  32'(DM_ADDR),   32'(addr));
      chk({tag, ".wdata"}, DM_WDATA,       wd);
      chk({tag, ".bubble"}, 32'(WB_VALID), 32'h0);
    end
    step();
    DM_ACK   = 1'b0;
    DM_RDATA = 32'h0;
    #1;
    chk({tag, ".req_cycles"},   32'(req_cnt),     32'(n_wait + 1));
    chk({tag, ".stall_cycles"}, 32'(stall_cnt),   32'(n_wait + 1));
    chk({tag, ".req_drop"},     32'(DM_REQ),      32'h0);
    chk({tag, ".wbv"},          32'(WB_VALID),    32'h1);
    chk({tag, ".wb_alu"},       WB_ALU_RES,       alu);
    chk({tag, ".wb_rdata"},     WB_DM_RDATA,      exp_rdata);
    chk({tag, ".wb_npc"},       32'(WB_NEXT_PC),  32'(npc));
    chk({tag, ".wb_rfs"},       32'(WB_RF_D_SEL), 32'(rfs));
    chk({tag, ".wb_err"},       32'(WB_ERR),      32'h0);
  endtask

  initial begin
    rst      = 1'b1;
    DM_ACK   = 1'b0;
    DM_RDATA = 32'h0;
    set_idle();
    step();
    step();
    chk_all_zero("reset");
    rst = 1'b0;

    // ALU-only: one-cycle pass-through, no stall, no request
    set_mem(1'b1, 1'b0, 1'b0, 32'h0000_1234, 32'hDEAD_BEEF, 16'h0077, 1'b1, 1'b0);
    #1;
    chk("alu.stall", 32'(MEM_STALL), 32'h0);
    step();
    chk("alu.wbv",    32'(WB_VALID),    32'h1);
    chk("alu.wb_alu", WB_ALU_RES,       32'h0000_1234);
    chk("alu.rdata",  WB_DM_RDATA,      32'h0);
    chk("alu.npc",    32'(WB_NEXT_PC),  32'h1);
    chk("alu.rfs",    32'(WB_RF_D_SEL), 32'h0);
    chk("alu.req",    32'(DM_REQ),      32'h0);
    set_idle();
    step();
    chk("idle.wbv",   32'(WB_VALID),   32'h0);
    chk("idle.hold",  WB_ALU_RES,      32'h0000_1234);

    // DM_ACK while IDLE must be ignored
    DM_ACK   = 1'b1;
    DM_RDATA = 32'h5555_AAAA;
    step();
    DM_ACK   = 1'b0;
    DM_RDATA = 32'h0;
    chk("idle_ack.wbv", 32'(WB_VALID), 32'h0);
    chk("idle_ack.req", 32'(DM_REQ),   32'h0);

    // Store, ack on the third request cycle; RE also set (store wins)
    mem_op("store", 1'b1, 1'b1, 16'h0040, 32'hCAFE_F00D, 32'h0000_0055, 1'b0, 1'b1,
           2, 32'h1111_2222, 32'h0);
    set_idle();
    step();

    // Load, ack on first ACCESS cycle
    mem_op("load", 1'b0, 1'b1, 16'h0100, 32'h0BAD_0BAD, 32'h0000_0100, 1'b0, 1'b1,
           0, 32'hA5A5_0001, 32'hA5A5_0001);
    set_idle();
    step();

    // Back-to-back loads: second arrives on the edge the first completes
    mem_op("b2b0", 1'b0, 1'b1, 16'h0010, 32'h0, 32'h0000_0010, 1'b1, 1'b1,
           0, 32'h1010_1010, 32'h1010_1010);
    mem_op("b2b1", 1'b0, 1'b1, 16'h0014, 32'h0, 32'h0000_0014, 1'b0, 1'b1,
           0, 32'h1414_1414, 32'h1414_1414);
    set_idle();
    step();
    chk("b2b.after_wbv", 32'(WB_VALID), 32'h0);

    // Reset two cycles into an access, then a late ack
    set_mem(1'b1, 1'b0, 1'b1, 32'h0000_0200, 32'h0, 16'h0200, 1'b1, 1'b1);
    step();
    chk("rst_acc.req1", 32'(DM_REQ), 32'h1);
    step();
    chk("rst_acc.req2", 32'(DM_REQ), 32'h1);
    rst = 1'b1;
    set_idle();
    step();
    chk_all_zero("rst_acc");
    rst    = 1'b0;
    DM_ACK = 1'b1;
    DM_RDATA = 32'hFFFF_0000;
    step();
    DM_ACK   = 1'b0;
    DM_RDATA = 32'h0;
    chk("late_ack.wbv",   32'(WB_VALID),  32'h0);
    chk("late_ack.req",   32'(DM_REQ),    32'h0);
    chk("late_ack.rdata", WB_DM_RDATA,    32'h0);

    // Normal ALU op after reset recovery
    set_mem(1'b1, 1'b0, 1'b0, 32'h0000_0ABC, 32'h0, 16'h0, 1'b0, 1'b1);
    step();
    chk("recov.wbv", 32'(WB_VALID),   32'h1);
    chk("recov.alu", WB_ALU_RES,      32'h0000_0ABC);
    chk("recov.rfs", 32'(WB_RF_D_SEL), 32'h1);
    set_idle();
    step();

`ifdef MEM_TIMEOUT_EN
    // No ack: abort after TO ACCESS cycles, then an ALU op clears the error
    set_mem(1'b1, 1'b0, 1'b1, 32'h0000_0300, 32'h0, 16'h0300, 1'b0, 1'b1);
    #1;
    chk("to.arr_stall", 32'(MEM_STALL), 32'h1);
    for (int c = 1; c <= TO; c++) begin
      step();
      chk("to.req",   32'(DM_REQ),    32'h1);
      chk("to.stall", 32'(MEM_STALL), (c < TO) ? 32'h1 : 32'h0);
    end
    step();
    chk("to.req_drop", 32'(DM_REQ),   32'h0);
    chk("to.wbv",      32'(WB_VALID), 32'h1);
    chk("to.err",      32'(WB_ERR),   32'h1);
    chk("to.rdata",    WB_DM_RDATA,   32'h0);
    set_mem(1'b1, 1'b0, 1'b0, 32'h0000_0777, 32'h0, 16'h0, 1'b0, 1'b0);
    #1;
    chk("to.post_stall", 32'(MEM_STALL), 32'h0);
    step();
    chk("to.clr_wbv", 32'(WB_VALID), 32'h1);
    chk("to.clr_err", 32'(WB_ERR),   32'h0);
    chk("to.clr_alu", WB_ALU_RES,    32'h0000_0777);
    set_idle();
    step();
`else
    // Without the timeout an unacknowledged access keeps waiting
    set_mem(1'b1, 1'b0, 1'b1, 32'h0000_0300, 32'h0, 16'h0300, 1'b0, 1'b1);
    for (int c = 1; c <= TO + 3; c++) begin
      step();
      chk("noto.req",   32'(DM_REQ),    32'h1);
      chk("noto.stall", 32'(MEM_STALL), 32'h1);
      chk("noto.wbv",   32'(WB_VALID),  32'h0);
      chk("noto.err",   32'(WB_ERR),    32'h0);
    end
    DM_ACK   = 1'b1;
    DM_RDATA = 32'h3030_3030;
    #1;
    chk("noto.ack_stall", 32'(MEM_STALL), 32'h0);
    step();
    DM_ACK   = 1'b0;
    DM_RDATA = 32'h0;
    set_idle();
    chk("noto.wbv",   32'(WB_VALID), 32'h1);
    chk("noto.rdata", WB_DM_RDATA,   32'h3030_3030);
    step();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
